ap_fifo_rr_arbiter: RTL and testbench
=====================================

AP_FIFO_RR_ARBITER -- requirements
Module: ap_fifo_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the word width of every channel and of the merged output.
REQ-002 SHALL have parameter NCH, default 3, meaning the number of requesting ap_fifo channels.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of each per-channel word counter.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port bus_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port ch_en, input, NCH bits: per-channel enable (configuration register).
REQ-008 SHALL have port burst_len, input, 8 bits: maximum words per grant; the value 0 is treated as 1.
REQ-009 SHALL have port cnt_clr, input, 1 bit: synchronous clear of all word counters.
REQ-010 SHALL have port src_dout, input, NCH*DATA_W bits: channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port src_empty_n, input, NCH bits: channel word available.
REQ-012 SHALL have port src_read, output, NCH bits: consume the current word of the channel.
REQ-013 SHALL have port dst_din, output, DATA_W bits: merged data.
REQ-014 SHALL have port dst_write, output, 1 bit: write strobe to the downstream FIFO.
REQ-015 SHALL have port dst_full, input, 1 bit: downstream FIFO full.
REQ-016 SHALL have port grant_id, output, 2 bits: index of the currently or most recently granted channel.
REQ-017 SHALL have port busy, output, 1 bit: high while a burst is active.
REQ-018 SHALL have port word_cnt, output, NCH*CNT_W bits: per-channel count of transferred words.

Function
REQ-019 SHALL implement a two-state FSM with states IDLE and BURST.
REQ-020 In IDLE, the block SHALL select the first eligible channel (ch_en[i] && src_empty_n[i]) scanning round-robin from last_grant+1, latch it into grant_id, load the burst counter from burst_len, and enter BURST the next cycle.
REQ-021 If no channel is eligible in IDLE, the block SHALL remain in IDLE with grant_id unchanged.
REQ-022 A transfer SHALL occur in BURST when src_empty_n[g] && !dst_full && ch_en[g] is true; in that cycle src_read[g] and dst_write SHALL both be 1, combinationally, in the same cycle.
REQ-023 dst_din SHALL equal src_dout of grant_id at all times, with zero added latency.
REQ-024 src_read[j] SHALL be 0 for every j other than the granted channel, and SHALL be 0 in IDLE.
REQ-025 Each transfer SHALL decrement the burst counter; the transfer that takes the counter from 1 to 0 SHALL return the FSM to IDLE and update last_grant to g.
REQ-026 In BURST, if src_empty_n[g] is 0 or ch_en[g] is 0, the block SHALL perform no transfer that cycle and return to IDLE, updating last_grant to g (early release).
REQ-027 dst_full alone SHALL stall the burst without releasing it.
REQ-028 Because IDLE lasts at least one cycle, there SHALL be a one-cycle gap between bursts.
REQ-029 word_cnt[g] SHALL increment by 1 per transfer and wrap modulo 2^CNT_W.
REQ-030 cnt_clr SHALL zero all counters and take priority over a simultaneous increment.
REQ-031 A change to burst_len during BURST SHALL have no effect until the next grant.
REQ-032 busy SHALL be 1 exactly when the FSM is in BURST.

Reset
REQ-033 On rst, the block SHALL enter IDLE with grant_id=0, last_grant=NCH-1 (so channel 0 is scanned first), burst counter=0, word_cnt=0, busy=0, src_read=0 and dst_write=0, all immediately and asynchronously.
REQ-034 If rst is asserted during BURST, the burst SHALL be abandoned with no further read or write strobes.

Structure
REQ-035 A shared package SHALL hold DATA_W, NCH, CNT_W, the state enum {IDLE, BURST} and the burst-length width.
REQ-036 The round-robin priority picker SHALL be one sub-module, rr_pick, which takes the request vector and last_grant and returns a found flag and an index.

Verification
REQ-037 Scenario single channel: ch_en=3'b111, burst_len=4, only ch1 has 10 words -> sequence 4 writes, gap, 4 writes, gap, 2 writes then release; word_cnt[1]=10.
REQ-038 Scenario all channels: all three channels continuously full, burst_len=2 -> grant order 0,1,2,0,...; each burst is 2 words with a 1-cycle gap.
REQ-039 Scenario backpressure: dst_full held high for 5 cycles mid-burst -> no strobes, grant held, burst resumes with its remaining count intact.
REQ-040 Scenario early release and disable: src_empty_n[g] drops, or ch_en[g] is cleared, mid-burst -> return to IDLE next cycle and the next eligible channel is granted.
REQ-041 Scenario counter wrap and clear: word_cnt preloaded near 2^CNT_W-1 via transfers, or CNT_W=4 -> wraps to 0; cnt_clr coincident with a transfer -> counter=0.
REQ-042 Scenario reset mid-burst: rst pulsed during BURST -> outputs zero at once and the first grant after release goes to channel 0.

Source files
------------

// File: rtl/ap_fifo_rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin ap_fifo merge arbiter.
// Imported by the picker and the top level.
package ap_fifo_rr_arbiter_pkg;

  localparam int DATA_W = 128;
  localparam int NCH    = 3;
  localparam int CNT_W  = 32;
  localparam int BLEN_W = 8;
  localparam int GID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // A programmed length of zero still grants a single word.
  function automatic logic [BLEN_W-1:0] eff_burst_len(input logic [BLEN_W-1:0] len);
    return (len == '0) ? BLEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/ap_fifo_rr_arbiter_rr_pick.sv
// Round-robin priority picker: first set request after last_grant, wrapping.
// Purely combinational.
module rr_pick
  import ap_fifo_rr_arbiter_pkg::*;
#(
  parameter int NCH   = ap_fifo_rr_arbiter_pkg::NCH,
  parameter int GID_W = ap_fifo_rr_arbiter_pkg::GID_W
) (
  input  logic [NCH-1:0]   req,
  input  logic [GID_W-1:0] last_grant,
  output logic             found,
  output logic [GID_W-1:0] idx
);

  logic [GID_W-1:0] cand;

  // Scan from the farthest candidate down so the nearest one is kept last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = GID_W'((int'(last_grant) + k) % NCH);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ap_fifo_rr_arbiter.sv
// Merges NCH ap_fifo sources into one downstream FIFO with round-robin bursts,
// per-channel word counters and a two-state IDLE/BURST controller.
module ap_fifo_rr_arbiter
  import ap_fifo_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = ap_fifo_rr_arbiter_pkg::DATA_W,
  parameter int NCH    = ap_fifo_rr_arbiter_pkg::NCH,
  parameter int CNT_W  = ap_fifo_rr_arbiter_pkg::CNT_W
) (
  input  logic                  bus_clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        ch_en,
  input  logic [BLEN_W-1:0]     burst_len,
  input  logic                  cnt_clr,
  input  logic [NCH*DATA_W-1:0] src_dout,
  input  logic [NCH-1:0]        src_empty_n,
  output logic [NCH-1:0]        src_read,
  output logic [DATA_W-1:0]     dst_din,
  output logic                  dst_write,
  input  logic                  dst_full,
  output logic [GID_W-1:0]      grant_id,
  output logic                  busy,
  output logic [NCH*CNT_W-1:0]  word_cnt,
  output state_t                state_dbg
);

  state_t              state_q, state_n;
  logic [GID_W-1:0]    grant_q, grant_n;
  logic [GID_W-1:0]    last_q, last_n;
  logic [BLEN_W-1:0]   bcnt_q, bcnt_n;
  logic [CNT_W-1:0]    cnt_q [NCH];
  logic [DATA_W-1:0]   src_words [NCH];
  logic                pick_found;
  logic [GID_W-1:0]    pick_idx;
  logic                grant_ok;
  logic                xfer;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign src_words[i]               = src_dout[i*DATA_W +: DATA_W];
    assign word_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  rr_pick #(.NCH(NCH), .GID_W(GID_W)) u_pick (
    .req        (ch_en & src_empty_n),
    .last_grant (last_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Handshake: a word moves only in BURST when the granted source has a word,
  // is enabled and the sink is not full; src_read[g] and dst_write then pulse
  // together in that same cycle, so source pop and sink push never diverge.
  assign grant_ok  = src_empty_n[grant_q] && ch_en[grant_q];
  assign xfer      = (state_q == BURST) && grant_ok && !dst_full;
  assign dst_write = xfer;
  assign dst_din   = src_words[grant_q];
  assign grant_id  = grant_q;
  assign busy      = (state_q == BURST);
  assign state_dbg = state_q;

  always_comb begin
    src_read = '0;
    if (xfer) src_read[grant_q] = 1'b1;
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    last_n  = last_q;
    bcnt_n  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_n = pick_idx;
          bcnt_n  = eff_burst_len(burst_len);
          state_n = BURST;
        end
      end
      BURST: begin
        // A missing word or a disabled channel ends the burst; full only stalls.
        if (!grant_ok) begin
          state_n = IDLE;
          last_n  = grant_q;
        end else if (!dst_full) begin
          bcnt_n = bcnt_q - BLEN_W'(1);
          if (bcnt_q == BLEN_W'(1)) begin
            state_n = IDLE;
            last_n  = grant_q;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GID_W'(NCH - 1);
      bcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      last_q  <= last_n;
      bcnt_q  <= bcnt_n;
    end
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cnt_clr)
          cnt_q[i] <= '0;
        else if (xfer && grant_q == GID_W'(i))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ap_fifo_rr_arbiter.sv
// Directed scenarios plus a randomized phase for ap_fifo_rr_arbiter, checked
// against a transaction-level model of the round-robin burst rules.
module tb_ap_fifo_rr_arbiter;
  import ap_fifo_rr_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int N  = 3;
  localparam int CW = 4;

  logic            bus_clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_en;
  logic [7:0]      burst_len;
  logic            cnt_clr;
  logic [N*DW-1:0] src_dout;
  logic [N-1:0]    src_empty_n;
  logic [N-1:0]    src_read;
  logic [DW-1:0]   dst_din;
  logic            dst_write;
  logic            dst_full;
  logic [1:0]      grant_id;
  logic            busy;
  logic [N*CW-1:0] word_cnt;
  state_t          state_dbg;

  ap_fifo_rr_arbiter #(.DATA_W(DW), .NCH(N), .CNT_W(CW)) dut (
    .bus_clk     (bus_clk),
    .rst         (rst),
    .ch_en       (ch_en),
    .burst_len   (burst_len),
    .cnt_clr     (cnt_clr),
    .src_dout    (src_dout),
    .src_empty_n (src_empty_n),
    .src_read    (src_read),
    .dst_din     (dst_din),
    .dst_write   (dst_write),
    .dst_full    (dst_full),
    .grant_id    (grant_id),
    .busy        (busy),
    .word_cnt    (word_cnt),
    .state_dbg   (state_dbg)
  );

  always #5 bus_clk = ~bus_clk;

  // source FIFO contents, scoreboard and counters
  logic [DW-1:0] fq [N][$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] drv [N];
  int            glog [$];
  int            checks = 0;
  int            errors = 0;
  int            n_writes = 0;
  bit            prev_busy = 1'b0;

  // stimulus shadows applied at the falling edge
  logic [N-1:0]  en_v = '1;
  logic [7:0]    bl_v = 8'd4;
  bit            clr_v = 1'b0;
  bit            full_v = 1'b0;

  // reference model
  bit            m_burst;
  int            m_g, m_last, m_rem;
  logic [CW-1:0] m_cnt [N];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*CW-1:0] model_cnt();
    logic [N*CW-1:0] v;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = m_cnt[i];
    return v;
  endfunction

  task automatic model_reset();
    m_burst = 1'b0;
    m_g     = 0;
    m_last  = N - 1;
    m_rem   = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
    exp_q.delete();
    prev_busy = 1'b0;
  endtask

  task automatic fill(input int ch, input int n);
    repeat (n) fq[ch].push_back(DW'($urandom));
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) fq[i].delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge bus_clk);
    rst = 1'b1;
    #1;
    chk({tag, "_src_read"}, src_read, '0);
    chk({tag, "_dst_write"}, dst_write, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_grant_id"}, grant_id, 2'd0);
    chk({tag, "_word_cnt"}, word_cnt, '0);
    chk({tag, "_state"}, state_dbg, IDLE);
    model_reset();
    @(posedge bus_clk);
    #2 rst = 1'b0;
  endtask

  task automatic step();
    logic         x;
    logic [N-1:0] rd;
    logic [DW-1:0] w;
    bit           found;
    int           c;
    @(negedge bus_clk);
    ch_en = en_v; burst_len = bl_v; cnt_clr = clr_v; dst_full = full_v;
    for (int i = 0; i < N; i++) begin
      drv[i] = (fq[i].size() != 0) ? fq[i][0] : DW'($urandom);
      src_empty_n[i] = (fq[i].size() != 0);
      src_dout[i*DW +: DW] = drv[i];
    end
    #1;
    x  = m_burst && en_v[m_g] && (fq[m_g].size() != 0) && !full_v;
    rd = '0;
    if (x) rd[m_g] = 1'b1;
    chk("busy", busy, m_burst);
    chk("state", state_dbg, m_burst ? BURST : IDLE);
    chk("grant_id", grant_id, m_g);
    chk("dst_write", dst_write, x);
    chk("src_read", src_read, rd);
    chk("dst_din", dst_din, drv[m_g]);
    chk("word_cnt", word_cnt, model_cnt());
    if (x) exp_q.push_back(fq[m_g][0]);
    if (dst_write) begin
      n_writes++;
      if (exp_q.size() == 0) chk("sb_unexpected_write", 1'b1, 1'b0);
      else begin
        w = exp_q.pop_front();
        chk("sb_data", dst_din, w);
      end
    end
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;
    // advance the model by one clock
    if (m_burst) begin
      if (!(en_v[m_g] && fq[m_g].size() != 0)) begin
        m_burst = 1'b0; m_last = m_g;
      end else if (!full_v) begin
        m_cnt[m_g] = m_cnt[m_g] + 1'b1;
        m_rem--;
        if (m_rem == 0) begin m_burst = 1'b0; m_last = m_g; end
      end
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && en_v[c] && fq[c].size() != 0) begin
          found = 1'b1; m_g = c; m_burst = 1'b1;
          m_rem = (bl_v == 0) ? 1 : int'(bl_v);
        end
      end
    end
    if (clr_v) for (int i = 0; i < N; i++) m_cnt[i] = '0;
    for (int i = 0; i < N; i++)
      if (src_read[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    @(posedge bus_clk);
  endtask

  initial begin
    int base;
    rst = 1'b1; ch_en = '0; burst_len = '0; cnt_clr = 1'b0;
    src_dout = '0; src_empty_n = '0; dst_full = 1'b0;
    model_reset();
    do_reset("por");

    // single channel: ch1 with 10 words, bursts of 4
    en_v = 3'b111; bl_v = 8'd4; fill(1, 10); n_writes = 0; glog.delete();
    repeat (25) step();
    chk("s1_writes", n_writes, 10);
    #1 chk("s1_cnt1", word_cnt[CW +: CW], 4'd10);
    chk("s1_bursts", glog.size(), 3);
    chk("s1_grant_last", glog[2], 1);

    // all channels busy, bursts of 2
    do_reset("s2");
    bl_v = 8'd2; n_writes = 0; glog.delete();
    for (int i = 0; i < 30; i++) begin
      for (int ch = 0; ch < N; ch++) if (fq[ch].size() < 4) fill(ch, 4 - fq[ch].size());
      step();
    end
    chk("s2_writes", n_writes, 20);
    for (int i = 0; i < 6; i++) chk("s2_order", glog[i], i % 3);

    // backpressure: dst_full high for 5 cycles mid-burst
    drain(); repeat (3) step();
    fill(0, 8); bl_v = 8'd6; n_writes = 0;
    for (int i = 0; i < 16; i++) begin
      full_v = (i >= 3 && i < 8);
      step();
    end
    full_v = 1'b0;
    chk("s3_writes", n_writes, 8);

    // early release on empty, then on disable
    drain();
    do_reset("s4");
    fill(0, 3); fill(2, 5); bl_v = 8'd8; n_writes = 0; glog.delete();
    for (int i = 0; i < 12; i++) begin
      en_v = (i >= 8) ? 3'b011 : 3'b111;
      step();
    end
    en_v = 3'b111;
    chk("s4_writes", n_writes, 5);
    chk("s4_grants", glog.size(), 2);
    chk("s4_first", glog[0], 0);
    chk("s4_second", glog[1], 2);

    // counter wrap at CNT_W=4, then clear coincident with a transfer
    clr_v = 1'b1; step(); clr_v = 1'b0;
    fill(0, 20); bl_v = 8'd255;
    repeat (40) step();
    #1 chk("s5_wrap", word_cnt[0 +: CW], 4'd4);
    fill(0, 6);
    for (int i = 0; i < 10; i++) begin
      if (m_burst && fq[m_g].size() != 0 && en_v[m_g]) break;
      step();
    end
    base = n_writes;
    clr_v = 1'b1; step(); clr_v = 1'b0;
    chk("s5_clr_xfer", n_writes - base, 1);
    #1 chk("s5_clr_wins", word_cnt, '0);

    // reset in the middle of a burst
    drain(); repeat (2) step();
    fill(1, 6); bl_v = 8'd6;
    for (int i = 0; i < 10; i++) begin
      if (m_burst) break;
      step();
    end
    repeat (2) step();
    #1 chk("s6_pre_busy", busy, 1'b1);
    do_reset("s6");
    fill(0, 3); fill(2, 3); glog.delete();
    repeat (4) step();
    chk("s6_first_grant", glog[0], 0);

    // randomized traffic
    for (int s = 0; s < 800; s++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 3) == 0 && fq[ch].size() < 6) fill(ch, $urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) en_v = N'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) bl_v = 8'($urandom_range(0, 5));
      full_v = ($urandom_range(0, 4) == 0);
      clr_v  = ($urandom_range(0, 50) == 0);
      if ($urandom_range(0, 299) == 0) do_reset("rand");
      else step();
    end
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
